// File: rtl/utopia1_phy_cell_source_pkg.sv
// Shared ATM/Utopia definitions: cell type, PHY source state and the header HEC function.
package utopia1_phy_cell_source_pkg;

  localparam int unsigned CellOctets = 53;
  localparam int unsigned IdxW       = 6;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(CellOctets - 1);

  // Mem[0] is the first octet on the wire and occupies the most significant byte.
  typedef struct packed {
    logic [0:CellOctets-1][7:0] Mem;
  } ATMCellType;

  typedef enum logic [1:0] {
    StIdle,
    StReady,
    StSend
  } UtopiaPhyStateType;

  // CRC-8 (x^8+x^2+x+1), zero seed, MSB first over the four header octets, coset 8'h55.
  function automatic logic [7:0] hec(input logic [31:0] header);
    logic [7:0] crc;
    logic       fb;
    crc = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb  = crc[7] ^ header[i];
      crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return crc ^ 8'h55;
  endfunction

endpackage

// File: rtl/utopia1_phy_cell_source_hec_gen.sv
// Combinational HEC generator over a 32-bit ATM header.
module atm_hec_gen
  import utopia1_phy_cell_source_pkg::*;
(
  input  logic [31:0] header,
  output logic [7:0]  hec_value
);

  // Wraps the shared package function so every user computes the same HEC.
  always_comb begin
    hec_value = hec(header);
  end

endmodule

// File: rtl/utopia1_phy_cell_source.sv
// Utopia level-1 PHY cell source: double-buffered 53-octet cells streamed under en_n/clav.
module utopia1_phy_cell_source
  import utopia1_phy_cell_source_pkg::*;
#(
  parameter bit          GenHEC = 1'b1,
  parameter int unsigned CntW   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  ATMCellType      cell_in,
  input  logic            cell_valid,
  output logic            cell_ready,
  input  logic            hec_err_inject,
  input  logic            en_n,
  output logic            clav,
  output logic [7:0]      data,
  output logic            soc,
  output logic [CntW-1:0] cell_cnt
);

  UtopiaPhyStateType state_q, state_d;
  ATMCellType        active_q, active_d;
  ATMCellType        pending_q, pending_d;
  logic              pending_full_q, pending_full_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [7:0]        data_q, data_d;
  logic              soc_q, soc_d;
  logic              clav_q, clav_d;
  logic [CntW-1:0]   cell_cnt_q, cell_cnt_d;

  logic       [7:0] gen_hec;
  ATMCellType       load_cell;
  logic             accept;
  logic             issue;

  atm_hec_gen u_hec_gen (
    .header    ({cell_in.Mem[0], cell_in.Mem[1], cell_in.Mem[2], cell_in.Mem[3]}),
    .hec_value (gen_hec)
  );

  // Cell as it will be stored: octet 4 optionally regenerated, then optionally corrupted.
  always_comb begin
    load_cell = cell_in;
    if (GenHEC) begin
      load_cell.Mem[4] = gen_hec;
    end
    load_cell.Mem[4] = load_cell.Mem[4] ^ {7'b0, hec_err_inject};
  end

  assign accept = cell_valid && !pending_full_q;
  // The active buffer is full exactly when the state is not idle.
  assign issue  = !en_n && (state_q != StIdle);

  // Next-state: octet issue and end-of-cell first, then place any accepted cell.
  always_comb begin
    state_d        = state_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    idx_d          = idx_q;
    data_d         = data_q;
    soc_d          = 1'b0;
    cell_cnt_d     = cell_cnt_q;

    if (issue) begin
      data_d = active_q.Mem[idx_q];
      soc_d  = (idx_q == '0);
      if (idx_q == LastIdx) begin
        cell_cnt_d = cell_cnt_q + CntW'(1);
        idx_d      = '0;
        if (pending_full_q) begin
          active_d       = pending_q;
          pending_full_d = 1'b0;
          state_d        = StReady;
        end else begin
          state_d = StIdle;
        end
      end else begin
        idx_d   = idx_q + IdxW'(1);
        state_d = StSend;
      end
    end

    // Decided on the post-issue view so a cell freed at end-of-cell is reused at once.
    if (accept) begin
      if (state_d == StIdle) begin
        active_d = load_cell;
        idx_d    = '0;
        state_d  = StReady;
      end else begin
        pending_d      = load_cell;
        pending_full_d = 1'b1;
      end
    end

    clav_d = (state_d == StReady) || pending_full_d;
  end

  // State and output registers; reset aborts any partial cell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      idx_q          <= '0;
      data_q         <= 8'h00;
      soc_q          <= 1'b0;
      clav_q         <= 1'b0;
      cell_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      soc_q          <= soc_d;
      clav_q         <= clav_d;
      cell_cnt_q     <= cell_cnt_d;
    end
  end

  assign cell_ready = !pending_full_q;
  assign clav       = clav_q;
  assign data       = data_q;
  assign soc        = soc_q;
  assign cell_cnt   = cell_cnt_q;

endmodule
